// File: rtl/sdram_cache_pkg.sv
// Shared definitions for the SDRAM write-through word cache.
//   cache_state_t : controller FSM encoding
//   ADDR_W        : word address width of the SDRAM controller
//   tag_width()   : tag bits left over after the line index
//   byte_lanes()  : number of byte enables covering a given word width
package sdram_cache_pkg;

    localparam int ADDR_W = 21;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_LOOKUP  = 3'd2,
        ST_MISS_RD = 3'd3,
        ST_WR_THRU = 3'd4,
        ST_RESP    = 3'd5,
        ST_FLUSH   = 3'd6
    } cache_state_t;

    function automatic int tag_width(input int addr_w, input int index_bits);
        return addr_w - index_bits;
    endfunction

    function automatic int byte_lanes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/sdram_cache_ram.sv
// Single-port synchronous RAM, 1-cycle read latency, per-byte write enable.
// Read-first: a write and a read of the same address in one cycle return the
// old contents. The top byte lane may be narrower than 8 bits.
//   clk    in   1                 clock
//   addr   in   DEPTH_BITS        read/write address
//   we     in   1                 write strobe
//   be     in   ceil(WIDTH/8)     byte enables, qualified by we
//   wdata  in   WIDTH             write data
//   rdata  out  WIDTH             registered read data
module sdram_cache_ram #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_BITS = 8
) (
    input  logic                       clk,
    input  logic [DEPTH_BITS-1:0]      addr,
    input  logic                       we,
    input  logic [(WIDTH+7)/8-1:0]     be,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata
);

    localparam int DEPTH = 2 ** DEPTH_BITS;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] bmask;

    // Expand byte enables to a bit mask so partial top lanes need no special case.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bm
        assign bmask[i] = be[i/8];
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= (mem[addr] & ~bmask) | (wdata & bmask);
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sdram_wt_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache in front of the
// SDRAM controller. One 32-bit word per line. Read hits never touch SDRAM;
// every write is forwarded. Line valid bits live in the tag RAM and are
// cleared by a full sweep after reset and on flush.
//   clk, reset        clock; synchronous active-high reset
//   flush             pulse: invalidate all lines (latched if not idle)
//   cpu_addr/din      request address (word) and write data, held while cpu_valid
//   cpu_wmask         0 = read, nonzero = byte-masked write
//   cpu_valid         request, held until cpu_ready
//   cpu_dout          read data, valid with cpu_ready
//   cpu_ready         one-cycle completion pulse
//   mem_addr/din/wmask/valid  to controller
//   mem_dout/ready    from controller
//   busy              high while the invalidate sweep runs
module sdram_wt_cache #(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_W     = sdram_cache_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_din,
    input  logic [3:0]        cpu_wmask,
    input  logic              cpu_valid,
    output logic [31:0]       cpu_dout,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [3:0]        mem_wmask,
    output logic              mem_valid,
    input  logic [31:0]       mem_dout,
    input  logic              mem_ready,
    output logic              busy
);

    import sdram_cache_pkg::*;

    localparam int TAG_W = tag_width(ADDR_W, INDEX_BITS);
    localparam int TV_W  = TAG_W + 1;            // {valid, tag}
    localparam int TV_BE = byte_lanes(TV_W);
    localparam logic [INDEX_BITS-1:0] SWEEP_LAST = '1;

    cache_state_t state, state_nx;

    logic [INDEX_BITS-1:0] sweep;
    logic                  flush_pend;
    logic                  req_q;
    logic [3:0]            wmask_q;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  sweeping;
    logic                  is_write;
    logic                  hit;

    logic [INDEX_BITS-1:0] ram_addr;
    logic                  tv_we;
    logic [TV_W-1:0]       tv_wdata;
    logic [TV_W-1:0]       tv_rdata;
    logic                  dat_we;
    logic [3:0]            dat_be;
    logic [31:0]           dat_wdata;
    logic [31:0]           dat_rdata;

    assign idx      = cpu_addr[INDEX_BITS-1:0];
    assign tag      = cpu_addr[ADDR_W-1:INDEX_BITS];
    assign sweeping = (state == ST_INIT) || (state == ST_FLUSH);
    assign is_write = |wmask_q;
    // Only meaningful in LOOKUP, one cycle after the IDLE read was issued.
    assign hit      = tv_rdata[TAG_W] && (tv_rdata[TAG_W-1:0] == tag);

    sdram_cache_ram #(.WIDTH(TV_W), .DEPTH_BITS(INDEX_BITS)) u_tag_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (tv_we),
        .be    ({TV_BE{1'b1}}),
        .wdata (tv_wdata),
        .rdata (tv_rdata)
    );

    sdram_cache_ram #(.WIDTH(32), .DEPTH_BITS(INDEX_BITS)) u_data_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (dat_we),
        .be    (dat_be),
        .wdata (dat_wdata),
        .rdata (dat_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_INIT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            // A flush during the sweep restarts it, so only leave on a quiet last step.
            ST_INIT, ST_FLUSH:
                if (!flush && sweep == SWEEP_LAST) state_nx = ST_IDLE;
            ST_IDLE:
                if (flush_pend || flush) state_nx = ST_FLUSH;
                else if (cpu_valid)      state_nx = ST_LOOKUP;
            ST_LOOKUP:
                if (is_write)  state_nx = ST_WR_THRU;
                else if (hit)  state_nx = ST_RESP;
                else           state_nx = ST_MISS_RD;
            ST_MISS_RD:
                if (mem_ready) state_nx = ST_RESP;
            ST_WR_THRU:
                if (mem_ready) state_nx = ST_RESP;
            ST_RESP:
                state_nx = ST_IDLE;
            default:
                state_nx = ST_INIT;
        endcase
    end

    // RAM port control: sweep owns the address while busy, otherwise the CPU index.
    always_comb begin
        ram_addr  = sweeping ? sweep : idx;
        tv_we     = 1'b0;
        tv_wdata  = '0;
        dat_we    = 1'b0;
        dat_be    = 4'h0;
        dat_wdata = cpu_din;
        unique case (state)
            ST_INIT, ST_FLUSH: begin
                tv_we = 1'b1;                    // valid=0
            end
            ST_LOOKUP: begin
                if (is_write && hit) begin       // write hit: merge enabled bytes
                    dat_we = 1'b1;
                    dat_be = wmask_q;
                end
            end
            ST_MISS_RD: begin
                if (mem_ready) begin             // refill line
                    tv_we     = 1'b1;
                    tv_wdata  = {1'b1, tag};
                    dat_we    = 1'b1;
                    dat_be    = 4'hF;
                    dat_wdata = mem_dout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sweep      <= '0;
            flush_pend <= 1'b0;
            req_q      <= 1'b0;
            wmask_q    <= 4'h0;
            cpu_dout   <= 32'h0;
        end else begin
            // Sweep wraps to 0 after the last line, ready for the next flush.
            if (sweeping)
                sweep <= flush ? '0 : sweep + 1'b1;
            else
                sweep <= '0;

            if (sweeping || (state == ST_IDLE && state_nx == ST_FLUSH))
                flush_pend <= 1'b0;
            else if (flush)
                flush_pend <= 1'b1;

            if (state == ST_IDLE && state_nx == ST_LOOKUP)
                wmask_q <= cpu_wmask;

            if (state == ST_LOOKUP && (state_nx == ST_MISS_RD || state_nx == ST_WR_THRU))
                req_q <= 1'b1;
            else if (mem_ready)
                req_q <= 1'b0;

            if (state == ST_LOOKUP && !is_write && hit)
                cpu_dout <= dat_rdata;
            else if (state == ST_MISS_RD && mem_ready)
                cpu_dout <= mem_dout;
        end
    end

    // The controller looks at valid in the same cycle it pulses ready, so valid
    // must already be gone then or it would start a second access.
    assign mem_valid = req_q & ~mem_ready;
    assign mem_addr  = cpu_addr;
    assign mem_din   = cpu_din;
    assign mem_wmask = (state == ST_WR_THRU) ? wmask_q : 4'h0;
    assign cpu_ready = (state == ST_RESP);
    assign busy      = sweeping;

endmodule

// File: tb/tb_sdram_wt_cache.sv
module tb_sdram_wt_cache;

    localparam int AW      = 21;
    localparam int MEM_LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_din;
    logic [3:0]    cpu_wmask;
    logic          cpu_valid;
    logic [31:0]   cpu_dout;
    logic          cpu_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [3:0]    mem_wmask;
    logic          mem_valid;
    logic [31:0]   mem_dout;
    logic          mem_ready;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    // controller model state
    logic [31:0]   sdram [logic [AW-1:0]];
    int            acc_cnt = 0;
    logic [AW-1:0] acc_addr;
    logic [3:0]    acc_mask;
    logic [31:0]   acc_din;

    logic [31:0]   exp_q [$];

    sdram_wt_cache #(.INDEX_BITS(8), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_wmask (cpu_wmask),
        .cpu_valid (cpu_valid),
        .cpu_dout  (cpu_dout),
        .cpu_ready (cpu_ready),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_wmask (mem_wmask),
        .mem_valid (mem_valid),
        .mem_dout  (mem_dout),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [AW-1:0] a);
        if (sdram.exists(a)) return sdram[a];
        return {11'h5A5, a};
    endfunction

    // SDRAM controller model: accept valid, respond after MEM_LAT cycles with a
    // one-cycle ready pulse; valid must already be low during that pulse.
    initial begin
        logic [31:0] w;
        mem_ready = 1'b0;
        mem_dout  = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1) begin
                acc_cnt++;
                acc_addr = mem_addr;
                acc_mask = mem_wmask;
                acc_din  = mem_din;
                w = rd_mem(mem_addr);
                if (mem_wmask != 4'h0) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_wmask[b]) w[b*8 +: 8] = mem_din[b*8 +: 8];
                    sdram[mem_addr] = w;
                end
                repeat (MEM_LAT) @(negedge clk);
                mem_dout  = w;
                mem_ready = 1'b1;
                #1 chk("valid_during_ready", {31'h0, mem_valid}, 32'h0);
                @(negedge clk);
                mem_ready = 1'b0;
            end
        end
    end

    // Wait for cpu_ready, then check the scoreboard entry and controller traffic.
    task automatic collect(input string nm, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] m, input int acc0, input int exp_acc,
                           input int exp_lat);
        int cyc = 0;
        logic [31:0] e;
        while (cpu_ready !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cpu_ready !== 1'b1) chk({nm, "_timeout"}, 32'h0, 32'h1);
        cpu_valid = 1'b0;
        e = exp_q.pop_front();
        if (m == 4'h0) chk({nm, "_data"}, cpu_dout, e);
        if (exp_lat > 0) chk({nm, "_lat"}, cyc, exp_lat);
        chk({nm, "_nacc"}, acc_cnt - acc0, exp_acc);
        if (exp_acc > 0) begin
            chk({nm, "_maddr"}, {11'h0, acc_addr}, {11'h0, a});
            chk({nm, "_mmask"}, {28'h0, acc_mask}, {28'h0, m});
            if (m != 4'h0) chk({nm, "_mdin"}, acc_din, d);
        end
    endtask

    task automatic cpu_op(input string nm, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic [31:0] exp_rd,
                          input int exp_acc, input int exp_lat);
        int acc0;
        @(posedge clk);
        #1;
        acc0      = acc_cnt;
        cpu_addr  = a;
        cpu_din   = d;
        cpu_wmask = m;
        cpu_valid = 1'b1;
        exp_q.push_back(exp_rd);
        collect(nm, a, d, m, acc0, exp_acc, exp_lat);
    endtask

    // Count cycles with busy high, starting at a negedge; optionally pulse
    // flush at cycle restart_at to restart the sweep.
    task automatic count_busy(input int restart_at, output int n, output int early);
        n = 0;
        early = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            if (cpu_ready === 1'b1) early++;
            flush = (n == restart_at);
            @(negedge clk);
        end
        flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        int n, early, acc0;
        reset     = 1'b1;
        flush     = 1'b0;
        cpu_valid = 1'b0;
        cpu_addr  = '0;
        cpu_din   = '0;
        cpu_wmask = '0;
        sdram[21'h00010] = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_ready", {31'h0, cpu_ready}, 32'h0);
        chk("rst_cpu_dout",  cpu_dout, 32'h0);
        chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
        chk("rst_busy",      {31'h0, busy}, 32'h1);

        // Release reset and present a cold read during the init sweep.
        @(posedge clk);
        #1;
        reset     = 1'b0;
        acc0      = acc_cnt;
        cpu_addr  = 21'h00010;
        cpu_wmask = 4'h0;
        cpu_valid = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        count_busy(0, n, early);
        chk("init_busy_cycles", n, 256);
        chk("init_early_ack", early, 0);
        collect("cold_rd", 21'h00010, 32'h0, 4'h0, acc0, 1, -1);

        cpu_op("hit_rd",      21'h00010, 32'h0,        4'h0,    32'hDEADBEEF, 0, 3);
        cpu_op("wr_hit",      21'h00010, 32'h11223344, 4'b0011, 32'h0,        1, -1);
        cpu_op("rd_merged",   21'h00010, 32'h0,        4'h0,    32'hDEAD3344, 0, 3);
        cpu_op("alias_miss",  21'h00110, 32'h0,        4'h0,    {11'h5A5, 21'h00110}, 1, -1);
        cpu_op("alias_hit",   21'h00110, 32'h0,        4'h0,    {11'h5A5, 21'h00110}, 0, 3);
        cpu_op("evicted_rd",  21'h00010, 32'h0,        4'h0,    32'hDEAD3344, 1, -1);
        cpu_op("wr_miss",     21'h00020, 32'hA5A5A5A5, 4'hF,    32'h0,        1, -1);
        cpu_op("rd_no_alloc", 21'h00020, 32'h0,        4'h0,    32'hA5A5A5A5, 1, -1);
        cpu_op("rd_20_hit",   21'h00020, 32'h0,        4'h0,    32'hA5A5A5A5, 0, 3);

        // Flush pulsed while the write-through is in flight.
        fork
            cpu_op("wr_flush", 21'h00010, 32'h99887766, 4'b1100, 32'h0, 1, -1);
            begin : fl
                int k;
                k = 0;
                while (mem_valid !== 1'b1 && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                chk("flush_in_wrthru", {31'h0, mem_valid}, 32'h1);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
        join

        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("flush_started", {31'h0, busy}, 32'h1);
        // Second flush 100 cycles in restarts the sweep: 100 + 256 busy cycles.
        count_busy(100, n, early);
        chk("flush_busy_cycles", n, 356);

        cpu_op("post_flush_10", 21'h00010, 32'h0, 4'h0, 32'h99883344, 1, -1);
        cpu_op("post_flush_20", 21'h00020, 32'h0, 4'h0, 32'hA5A5A5A5, 1, -1);
        cpu_op("refill_hit_10", 21'h00010, 32'h0, 4'h0, 32'h99883344, 0, 3);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
